// File: rtl/tx_symbol_scheduler.sv
// tx_symbol_scheduler: picks lane content per cycle (NOT_READY/DATA/IDLE/CC),
// inserts periodic CC bursts, backpressures the AXI-S source, tracks frames.
// Ports:
//   clk, rst (sync, active-high)
//   channel_init_finished  channel up (level)
//   axi_valid, axi_last    source beat and end-of-frame flag
//   axi_ready              beat accepted this cycle
//   tx_sel                 0=IDLE 1=DATA 2=CC 3=NOT_READY
//   in_frame               frame open (registered)
//   cc_active              CC burst cycle
//   frame_abort            1-cycle pulse: channel lost mid-frame
module tx_symbol_scheduler #(
  parameter int CC_PERIOD = 10000,
  parameter int CC_LENGTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       channel_init_finished,
  input  logic       axi_valid,
  input  logic       axi_last,
  output logic       axi_ready,
  output logic [1:0] tx_sel,
  output logic       in_frame,
  output logic       cc_active,
  output logic       frame_abort
);

  localparam int TW = $clog2(CC_PERIOD);
  localparam int BW = $clog2(CC_LENGTH + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CC_PERIOD - 1);
  localparam logic [BW-1:0] B_LAST = BW'(CC_LENGTH - 1);

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_DATA = 2'd1;
  localparam logic [1:0] SEL_CC   = 2'd2;
  localparam logic [1:0] SEL_NRDY = 2'd3;

  typedef enum logic [1:0] {
    S_WAIT_INIT,
    S_RUN,
    S_CC
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          in_frame_q, in_frame_d;
  logic          abort_q, abort_d;
  logic          xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT_INIT;
      timer_q    <= '0;
      burst_q    <= '0;
      in_frame_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      burst_q    <= burst_d;
      in_frame_q <= in_frame_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    burst_d    = burst_q;
    in_frame_d = in_frame_q;
    abort_d    = 1'b0;
    axi_ready  = 1'b0;
    tx_sel     = SEL_NRDY;
    cc_active  = 1'b0;
    xfer       = 1'b0;
    unique case (state_q)
      S_WAIT_INIT: begin
        timer_d    = '0;
        burst_d    = '0;
        in_frame_d = 1'b0;
        if (channel_init_finished) state_d = S_RUN;
      end
      S_RUN: begin
        axi_ready = 1'b1;
        xfer      = axi_valid;
        tx_sel    = xfer ? SEL_DATA : SEL_IDLE;
        if (xfer) in_frame_d = !axi_last;
        if (!channel_init_finished) begin
          // A frame closed by this very beat is not aborted.
          abort_d    = in_frame_q && !(xfer && axi_last);
          state_d    = S_WAIT_INIT;
          timer_d    = '0;
          burst_d    = '0;
          in_frame_d = 1'b0;
        end else if (timer_q == T_LAST) begin
          state_d = S_CC;
          timer_d = '0;
          burst_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CC: begin
        tx_sel    = SEL_CC;
        cc_active = 1'b1;
        if (!channel_init_finished) begin
          abort_d    = in_frame_q;
          state_d    = S_WAIT_INIT;
          timer_d    = '0;
          burst_d    = '0;
          in_frame_d = 1'b0;
        end else if (burst_q == B_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
          burst_d = '0;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  assign in_frame    = in_frame_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// tb_tx_symbol_scheduler: directed bench for tx_symbol_scheduler,
// CC_PERIOD=8, CC_LENGTH=3.
module tb_tx_symbol_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       ready;
  logic [1:0] sel;
  logic       in_frame;
  logic       cc;
  logic       abort;

  int n_cmp = 0;
  int n_err = 0;

  tx_symbol_scheduler #(.CC_PERIOD(8), .CC_LENGTH(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .channel_init_finished(init),
    .axi_valid            (valid),
    .axi_last             (last),
    .axi_ready            (ready),
    .tx_sel               (sel),
    .in_frame             (in_frame),
    .cc_active            (cc),
    .frame_abort          (abort)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first RUN cycle (timer 0).
  task automatic init_seq();
    rst = 1'b1; init = 1'b0; valid = 1'b0; last = 1'b0;
    step();
    rst = 1'b0; init = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; valid = 1'b0; last = 1'b0;
    step(); step(); #1;
    n_cmp++; if (sel !== 2'd3) begin n_err++;
      $display("FAIL rst_sel got %0d want 3", sel); end
    n_cmp++; if (ready !== 1'b0) begin n_err++;
      $display("FAIL rst_ready got %b want 0", ready); end
    n_cmp++; if (cc !== 1'b0) begin n_err++;
      $display("FAIL rst_cc got %b want 0", cc); end
    n_cmp++; if (in_frame !== 1'b0 || abort !== 1'b0) begin n_err++;
      $display("FAIL rst_frame got %b%b want 00", in_frame, abort); end
    rst = 1'b0;
    step(); #1;
    n_cmp++; if (sel !== 2'd3) begin n_err++;
      $display("FAIL wait_sel got %0d want 3", sel); end
    init = 1'b1; #1;
    n_cmp++; if (sel !== 2'd3 || ready !== 1'b0) begin n_err++;
      $display("FAIL rise_cycle got sel=%0d rdy=%b want 3/0", sel, ready); end
    step(); #1;
    n_cmp++; if (sel !== 2'd0 || ready !== 1'b1) begin n_err++;
      $display("FAIL run_entry got sel=%0d rdy=%b want 0/1", sel, ready); end
  endtask

  task automatic test_cadence();
    int beats;
    logic [1:0] es;
    init_seq();
    valid = 1'b1; last = 1'b1; beats = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      es = ((k % 11) < 8) ? 2'd1 : 2'd2;
      n_cmp++; if (sel !== es || ready !== (es == 2'd1) || cc !== (es == 2'd2)) begin
        n_err++;
        $display("FAIL cadence k=%0d got sel=%0d rdy=%b cc=%b want sel=%0d",
                 k, sel, ready, cc, es);
      end
      if (k < 33 && ready === 1'b1) beats++;
      step();
    end
    n_cmp++; if (beats != 24) begin n_err++;
      $display("FAIL cadence_beats got %0d want 24", beats); end
    valid = 1'b0;
  endtask

  task automatic test_midframe_cc();
    logic [1:0] es;
    logic ef;
    init_seq();
    valid = 1'b0;
    repeat (4) step();
    for (int c = 0; c < 16; c++) begin
      valid = (c < 15); last = (c == 14);
      #1;
      es = (c >= 4 && c <= 6) || c == 15 ? 2'd2 : 2'd1;
      ef = (c >= 1 && c <= 14);
      n_cmp++; if (sel !== es || cc !== (es == 2'd2)) begin n_err++;
        $display("FAIL midframe_sel c=%0d got %0d/%b want %0d", c, sel, cc, es); end
      n_cmp++; if (in_frame !== ef) begin n_err++;
        $display("FAIL midframe_inframe c=%0d got %b want %b", c, in_frame, ef); end
      step();
    end
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_loss_midframe();
    init_seq();
    valid = 1'b1; last = 1'b0;
    repeat (3) step();
    valid = 1'b0; init = 1'b0; #1;
    n_cmp++; if (sel !== 2'd0 || in_frame !== 1'b1) begin n_err++;
      $display("FAIL loss_cycle got sel=%0d inf=%b want 0/1", sel, in_frame); end
    step();
    n_cmp++; if (sel !== 2'd3 || abort !== 1'b1 || in_frame !== 1'b0) begin n_err++;
      $display("FAIL loss_next got sel=%0d ab=%b inf=%b want 3/1/0",
               sel, abort, in_frame); end
    step();
    n_cmp++; if (abort !== 1'b0 || sel !== 2'd3) begin n_err++;
      $display("FAIL loss_pulse got ab=%b sel=%0d want 0/3", abort, sel); end
    init = 1'b1;
    step();
    for (int k = 0; k < 11; k++) begin
      #1;
      n_cmp++; if (cc !== (k >= 8) || sel !== ((k >= 8) ? 2'd2 : 2'd0)) begin
        n_err++;
        $display("FAIL reinit k=%0d got cc=%b sel=%0d", k, cc, sel);
      end
      step();
    end
  endtask

  task automatic test_loss_in_cc();
    init_seq();
    valid = 1'b0;
    repeat (8) step();
    n_cmp++; if (cc !== 1'b1) begin n_err++;
      $display("FAIL cc1 got %b want 1", cc); end
    step();
    init = 1'b0; #1;
    n_cmp++; if (cc !== 1'b1 || sel !== 2'd2) begin n_err++;
      $display("FAIL cc2 got cc=%b sel=%0d want 1/2", cc, sel); end
    step();
    n_cmp++; if (sel !== 2'd3 || cc !== 1'b0 || ready !== 1'b0) begin n_err++;
      $display("FAIL cc_loss got sel=%0d cc=%b rdy=%b want 3/0/0", sel, cc, ready); end
    n_cmp++; if (abort !== 1'b0) begin n_err++;
      $display("FAIL cc_loss_abort got %b want 0", abort); end
    init = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      #1;
      n_cmp++; if (cc !== (k == 8)) begin n_err++;
        $display("FAIL cc_reinit k=%0d got cc=%b", k, cc); end
      step();
    end
  endtask

  task automatic test_single_beat_mix();
    logic [1:0] es;
    init_seq();
    last = 1'b1;
    for (int k = 0; k < 22; k++) begin
      valid = (k % 2 == 0);
      #1;
      es = ((k % 11) < 8) ? (valid ? 2'd1 : 2'd0) : 2'd2;
      n_cmp++; if (sel !== es || in_frame !== 1'b0) begin n_err++;
        $display("FAIL mix k=%0d got sel=%0d inf=%b want %0d/0", k, sel, in_frame, es);
      end
      step();
    end
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_reset_midframe();
    init_seq();
    valid = 1'b1; last = 1'b0;
    step();
    n_cmp++; if (in_frame !== 1'b1) begin n_err++;
      $display("FAIL rmf_open got %b want 1", in_frame); end
    rst = 1'b1;
    step();
    n_cmp++; if (sel !== 2'd3 || in_frame !== 1'b0 || abort !== 1'b0) begin n_err++;
      $display("FAIL rmf_rst got sel=%0d inf=%b ab=%b want 3/0/0",
               sel, in_frame, abort); end
    rst = 1'b0;
    step();
    n_cmp++; if (abort !== 1'b0 || ready !== 1'b1) begin n_err++;
      $display("FAIL rmf_after got ab=%b rdy=%b want 0/1", abort, ready); end
    valid = 1'b0;
  endtask

  task automatic test_simultaneous();
    init_seq();
    valid = 1'b1; last = 1'b0;
    step();
    last = 1'b1; init = 1'b0; #1;
    n_cmp++; if (sel !== 2'd1) begin n_err++;
      $display("FAIL sim_last_sel got %0d want 1", sel); end
    step();
    n_cmp++; if (abort !== 1'b0 || sel !== 2'd3 || in_frame !== 1'b0) begin n_err++;
      $display("FAIL sim_last_loss got ab=%b sel=%0d inf=%b want 0/3/0",
               abort, sel, in_frame); end
    valid = 1'b0; last = 1'b0; init = 1'b1;
    step();
    repeat (7) step();
    init = 1'b0; #1;
    n_cmp++; if (sel !== 2'd0 || ready !== 1'b1) begin n_err++;
      $display("FAIL sim_t7 got sel=%0d rdy=%b want 0/1", sel, ready); end
    step();
    n_cmp++; if (sel !== 2'd3 || cc !== 1'b0) begin n_err++;
      $display("FAIL sim_expiry_loss got sel=%0d cc=%b want 3/0", sel, cc); end
    step();
    n_cmp++; if (sel !== 2'd3 || cc !== 1'b0) begin n_err++;
      $display("FAIL sim_stay_wait got sel=%0d cc=%b want 3/0", sel, cc); end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_midframe_cc();
    test_loss_midframe();
    test_loss_in_cc();
    test_single_beat_mix();
    test_reset_midframe();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
